apb_master_bridge: RTL
======================

# apb_master_bridge

Converts the CPU core's single-cycle data-bus requests (address, write data, byte enables) into APB4 transfers to up to four peripherals, and stalls the core until each transfer completes. Sits directly downstream of the datapath's bus port (busAddr/busWData/Byte_Enable/busRData), between the core and the peripheral fabric. It includes address decode, a wait-state handshake and a watchdog timeout.

## Interface
- NUM_SLAVES, 4: number of PSEL outputs (1..4)
- BASE_PAGE, 20'h10000: addr[31:12] of slave 0; slave i at page BASE_PAGE+i
- TIMEOUT, 255: max ACCESS cycles waiting for PREADY before forced error completion

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- busReq  in  1  core requests a data transfer this cycle
- busWe  in  1  1 = write, 0 = read
- busAddr  in  32  byte address
- busWData  in  32  lane-aligned write data
- busBe  in  4  byte enables from core
- busRData  out  32  read data, valid when busReady=1
- busReady  out  1  transfer complete; core may advance
- busError  out  1  with busReady: unmapped address or timeout
- PADDR  out  32  APB address
- PWRITE  out  1  APB direction
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB write strobes
- PRDATA  in  NUM_SLAVES*32  per-slave read data, slave i at [32i+31:32i]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
- FSM states IDLE, SETUP, ACCESS, ERR.
- IDLE: busReq=1 → capture addr/wdata/we/be into request registers; decode; mapped → SETUP, unmapped → ERR.
- SETUP: PSEL[sel]=1, PENABLE=0; unconditionally → ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1; timeout counter increments each cycle. PREADY[sel]=1 → busReady=1, busRData=PRDATA[sel], busError=PSLVERR[sel], → IDLE. Counter reaches TIMEOUT without PREADY → ERR.
- ERR: busReady=1, busError=1, busRData=0, → IDLE. No PSEL asserted.
- Decode: sel=i when busAddr[31:12]==BASE_PAGE+i, i<NUM_SLAVES; otherwise unmapped.
- PADDR, PWRITE, PWDATA, PSTRB driven from request registers; stable from SETUP through end of ACCESS.
- PSTRB = captured busBe on writes; forced 4'b0000 on reads.
- busRData = 0 whenever busReady=0.
- busReq ignored outside IDLE; core holds request stable until busReady.

## Timing
- Reset values: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, busReady=0, busError=0, busRData=0, counter=0.
- Zero-wait transfer: request at cycle N (IDLE), SETUP N+1, ACCESS N+2 with busReady=1 in N+2 (combinational from PREADY). Latency 3 cycles including request.
- Each PREADY-low ACCESS cycle adds one cycle.
- Unmapped: request N, ERR at N+1 with busReady=busError=1.
- Timeout: ERR entered the cycle after counter==TIMEOUT; busReady in that ERR cycle.
- Back-to-back: IDLE at N+3 may accept the next request; no bubble beyond IDLE.
- Reset mid-transfer: all outputs return to reset values immediately; no completion signalled.
- PREADY from non-selected slaves ignored.

## Structure
- Package apb_bridge_pkg: state enum (IDLE, SETUP, ACCESS, ERR), default BASE_PAGE, page width constant.
- Sub-module apb_addr_decoder: combinational busAddr → one-hot select + mapped flag.
- Top holds FSM, request registers, timeout counter (width $clog2(TIMEOUT+1)), read/ready mux.

## Test plan
- Write 0x1000_0004, data 0xDEADBEEF, be 4'b1111, slave 0 PREADY tied 1 → PSEL=0001 SETUP then ACCESS, PSTRB=1111, busReady at cycle 3, busError=0.
- Read 0x1000_2008, slave 2 PREADY low 3 cycles, PRDATA=0x12345678 → PSTRB=0000, busReady at cycle 6, busRData=0x12345678.
- Read 0x2000_0000 (unmapped) → no PSEL, busReady=busError=1 at cycle 2, busRData=0.
- Slave 1 never ready, TIMEOUT=4 → ERR after 4 ACCESS cycles, busError=1, PSEL dropped.
- Slave 3 PSLVERR=1 with PREADY → busError=1 in completion cycle; two back-to-back byte writes (be 0001, 0100) both complete with correct PSTRB.
- Assert reset during ACCESS → PSEL/PENABLE/busReady 0 immediately; next request after reset completes normally.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared FSM state type and address-page constants for the APB bridge
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;
  localparam int PAGE_W = 20;
  localparam logic [PAGE_W-1:0] DEF_BASE_PAGE = 20'h10000;
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a 4 KiB page number to a one-hot slave select
module apb_addr_decoder import apb_bridge_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter logic [PAGE_W-1:0] BASE_PAGE = DEF_BASE_PAGE
) (
  input  logic [PAGE_W-1:0]     page,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  mapped
);
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel[i] = page == BASE_PAGE + PAGE_W'(i);
  end
  assign mapped = |sel;
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single-cycle core bus requests into APB4 transfers,
// stalling the core until the slave answers, the address misses, or the watchdog fires
module apb_master_bridge import apb_bridge_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter logic [PAGE_W-1:0] BASE_PAGE = DEF_BASE_PAGE,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     busReq,
  input  logic                     busWe,
  input  logic [31:0]              busAddr,
  input  logic [31:0]              busWData,
  input  logic [3:0]               busBe,
  output logic [31:0]              busRData,
  output logic                     busReady,
  output logic                     busError,
  output logic [31:0]              PADDR,
  output logic                     PWRITE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  input  logic [NUM_SLAVES*32-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t                state;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  mapped;
  logic [CW-1:0]         cnt;
  logic                  hit;
  logic [31:0]           rdata;
  apb_addr_decoder #(.NUM_SLAVES(NUM_SLAVES), .BASE_PAGE(BASE_PAGE)) u_dec (
    .page(busAddr[31:12]),
    .sel(dec_sel),
    .mapped(mapped)
  );
  // Completion is combinational from the selected slave so a zero-wait access costs no extra cycle
  always_comb begin
    hit = state == ACCESS && |(PREADY & PSEL);
    rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) if (PSEL[i]) rdata = PRDATA[32*i +: 32];
    busReady = state == ERR || hit;
    busError = state == ERR || (hit && |(PSLVERR & PSEL));
    busRData = hit ? rdata : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (busReq) begin
          PADDR  <= busAddr;
          PWDATA <= busWData;
          PWRITE <= busWe;
          PSTRB  <= busWe ? busBe : 4'b0000;
          PSEL   <= dec_sel;
          state  <= mapped ? SETUP : ERR;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        // The TIMEOUT-th unanswered access cycle is the last one before forced error completion
        ACCESS: if (hit || cnt == CW'(TIMEOUT - 1)) begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          cnt     <= '0;
          state   <= hit ? IDLE : ERR;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
